walk_scheduler: RTL and testbench
=================================

// Module: walk_scheduler
// PURPOSE
//  Arbitrates the three latched pedestrian walk flags (Thevenin, NortonNorte, NortonSur)
//  and sequences one pedestrian phase at a time: request traffic stop, WALK, flashing
//  DON'T-WALK, all-red clearance, then pulse the matching flag clear.
//  Sits between the walk-flag register bank and the main traffic-light state machine.
//  Round-robin arbitration: no crosswalk starves when several flags stay set.
// PARAMETERS
//  WALK_T    8   ticks WALK light held steady (>=1)
//  FLASH_T   6   ticks of flashing DON'T-WALK (>=1)
//  CLEAR_T   2   ticks all-red clearance after flashing (>=1)
//  MIN_GAP   10  ticks between phases to give traffic time (>=1)
//  CNT_W     8   timer width; must hold max(WALK_T,FLASH_T,CLEAR_T,MIN_GAP)
// PORTS
//  clk             in   1      system clock, rising edge
//  resetN          in   1      async active-low reset
//  tick            in   1      1-cycle timebase enable; all timers advance only on tick
//  walkFlag        in   3      latched requests: [0]=Tv, [1]=NN, [2]=NS
//  trafficStopped  in   1      main FSM: vehicle lights red, crossing safe
//  trafficStopReq  out  1      request to main FSM to stop vehicle traffic
//  walkLight       out  3      one-hot steady WALK for served crosswalk
//  flashOn         out  1      DON'T-WALK flash phase (1 = lamp on) for served crosswalk
//  resetFlag       out  3      one-cycle clear pulse to flag register, one-hot
//  servedIdx       out  2      index of crosswalk being served (0..2), held all phase
//  busy            out  1      1 in any state except IDLE
// BEHAVIOUR
//  Reset (resetN=0, async): state=IDLE, rrPtr=0, timer=0; all outputs 0.
//  States:
//   IDLE : if any walkFlag=1, grant = first set bit searching rrPtr, rrPtr+1, rrPtr+2 (mod 3).
//          Latch grant into servedIdx, timer=0, -> REQ. No tick needed.
//   REQ  : trafficStopReq=1. On trafficStopped=1 -> WALK, timer=0. Waits indefinitely.
//   WALK : trafficStopReq=1, walkLight[servedIdx]=1. On tick timer++;
//          on tick with timer==WALK_T-1 -> FLASH, timer=0.
//   FLASH: trafficStopReq=1, flashOn=~timer[0] (lamp on at even ticks, first tick on).
//          On tick with timer==FLASH_T-1 -> CLEAR, timer=0.
//   CLEAR: trafficStopReq=1, all pedestrian lamps off. On tick with timer==CLEAR_T-1:
//          -> GAP, register resetFlag[servedIdx]=1 for exactly one cycle,
//          rrPtr=(servedIdx==2)?0:servedIdx+1, trafficStopReq drops next cycle.
//   GAP  : no request, no lamps. On tick with timer==MIN_GAP-1 -> IDLE.
//  Outputs are registered (decoded from next-state); one-cycle latency from transition.
//  Flag clear: flag register clears one cycle after resetFlag; GAP >=1 tick
//   guarantees the stale flag is never re-granted.
//  Flags set during a phase (any index, including served) are held by the flag
//   register and considered only in IDLE.
//  Simultaneous flags: exactly one served per phase; others wait for later phases.
//  trafficStopped dropping in WALK/FLASH/CLEAR is ignored; sequence completes
//   (main FSM must not release while trafficStopReq=1).
//  tick in REQ or IDLE has no effect. Timer never exceeds its phase limit; wrap not possible.
//  walkLight, flashOn, resetFlag are never active in the same cycle.
//  resetN asserted mid-phase: immediate return to reset values; flag not cleared
//   (request is re-served after reset).
// TESTING
//  1. Reset, walkFlag=3'b010, trafficStopped tied 1 -> servedIdx=1, walkLight=3'b010
//     for 8 ticks, flashOn 1,0,1,0,1,0 over 6 ticks, 2 ticks dark, resetFlag=3'b010 one cycle.
//  2. walkFlag=3'b111 held (model flag register) -> served order 0,1,2,0; each resetFlag one-hot.
//  3. walkFlag=3'b001, trafficStopped=0 for 20 cycles -> stays REQ, trafficStopReq=1,
//     walkLight=0; raise trafficStopped -> WALK next cycle.
//  4. After serving idx 0 with flag-register model, verify no re-grant of idx 0 during GAP
//     and IDLE reached after 10 ticks; busy=0 in IDLE.
//  5. resetN pulsed low during FLASH -> all outputs 0 asynchronously; after release with
//     flag still set, phase restarts from REQ for same index.
//  6. walkFlag=3'b100 set during phase for idx 0 -> served next phase after GAP, not earlier.

Source files
------------

// File: rtl/walk_scheduler_if.sv
// Signal bundle between the walk scheduler and its environment (flag bank + main FSM).
// The master modport is the scheduler side.
interface walk_scheduler_if;
  logic       tick;
  logic [2:0] walkFlag;
  logic       trafficStopped;
  logic       trafficStopReq;
  logic [2:0] walkLight;
  logic       flashOn;
  logic [2:0] resetFlag;
  logic [1:0] servedIdx;
  logic       busy;

  modport master (
    input  tick, walkFlag, trafficStopped,
    output trafficStopReq, walkLight, flashOn, resetFlag, servedIdx, busy
  );

  modport slave (
    output tick, walkFlag, trafficStopped,
    input  trafficStopReq, walkLight, flashOn, resetFlag, servedIdx, busy
  );
endinterface

// File: rtl/walk_scheduler.sv
// Round-robin pedestrian phase sequencer: stop traffic, WALK, flashing DON'T-WALK,
// all-red clearance, then a one-cycle clear pulse back to the walk-flag register.
module walk_scheduler #(
  parameter int unsigned WALK_T  = 8,
  parameter int unsigned FLASH_T = 6,
  parameter int unsigned CLEAR_T = 2,
  parameter int unsigned MIN_GAP = 10,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              resetN,
  walk_scheduler_if.master bus_io
);

  typedef enum logic [2:0] {StIdle, StReq, StWalk, StFlash, StClear, StGap} state_e;

  localparam logic [CNT_W-1:0] WalkLast  = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] FlashLast = CNT_W'(FLASH_T - 1);
  localparam logic [CNT_W-1:0] ClearLast = CNT_W'(CLEAR_T - 1);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'(MIN_GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       served_q, served_d;

  logic             stop_req_q, stop_req_d;
  logic [2:0]       walk_q, walk_d;
  logic             flash_q, flash_d;
  logic [2:0]       rflag_q, rflag_d;
  logic             busy_q, busy_d;

  logic [2:0]       flags_rot;
  logic [1:0]       grant_off;
  logic [2:0]       grant_sum;
  logic [1:0]       grant;
  logic             grant_vld;
  logic [CNT_W-1:0] phase_last;

  // Rotate the flags so bit 0 is the crosswalk at rr_ptr_q; the lowest set bit then wins.
  always_comb begin
    case (rr_ptr_q)
      2'd1:    flags_rot = {bus_io.walkFlag[0], bus_io.walkFlag[2], bus_io.walkFlag[1]};
      2'd2:    flags_rot = {bus_io.walkFlag[1], bus_io.walkFlag[0], bus_io.walkFlag[2]};
      default: flags_rot = bus_io.walkFlag;
    endcase
    grant_vld = |flags_rot;
    if (flags_rot[0]) begin
      grant_off = 2'd0;
    end else if (flags_rot[1]) begin
      grant_off = 2'd1;
    end else begin
      grant_off = 2'd2;
    end
    grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    grant     = (grant_sum >= 3'd3) ? 2'(grant_sum - 3'd3) : grant_sum[1:0];
  end

  always_comb begin
    case (state_q)
      StWalk:  phase_last = WalkLast;
      StFlash: phase_last = FlashLast;
      StClear: phase_last = ClearLast;
      default: phase_last = GapLast;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_ptr_d = rr_ptr_q;
    served_d = served_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          served_d = grant;
          timer_d  = '0;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (bus_io.trafficStopped) begin
          timer_d = '0;
          state_d = StWalk;
        end
      end
      StWalk, StFlash, StClear, StGap: begin
        if (bus_io.tick) begin
          if (timer_q == phase_last) begin
            timer_d = '0;
            unique case (state_q)
              StWalk:  state_d = StFlash;
              StFlash: state_d = StClear;
              StClear: begin
                state_d  = StGap;
                rr_ptr_d = (served_q == 2'd2) ? 2'd0 : served_q + 2'd1;
              end
              default: state_d = StIdle;
            endcase
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q after the edge.
  always_comb begin
    stop_req_d = (state_d == StReq) || (state_d == StWalk) ||
                 (state_d == StFlash) || (state_d == StClear);
    walk_d     = (state_d == StWalk) ? 3'(3'b001 << served_d) : 3'b000;
    flash_d    = (state_d == StFlash) && !timer_d[0];
    rflag_d    = (state_q == StClear && state_d == StGap) ? 3'(3'b001 << served_q) : 3'b000;
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      rr_ptr_q   <= 2'd0;
      served_q   <= 2'd0;
      stop_req_q <= 1'b0;
      walk_q     <= 3'b000;
      flash_q    <= 1'b0;
      rflag_q    <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rr_ptr_q   <= rr_ptr_d;
      served_q   <= served_d;
      stop_req_q <= stop_req_d;
      walk_q     <= walk_d;
      flash_q    <= flash_d;
      rflag_q    <= rflag_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_io.trafficStopReq = stop_req_q;
  assign bus_io.walkLight      = walk_q;
  assign bus_io.flashOn        = flash_q;
  assign bus_io.resetFlag      = rflag_q;
  assign bus_io.servedIdx      = served_q;
  assign bus_io.busy           = busy_q;

endmodule

// File: tb/tb_walk_scheduler.sv
// Bench for walk_scheduler: a procedural phase model plus a walk-flag register model,
// compared against the DUT every cycle, with directed scenarios and a random soak.
module tb_walk_scheduler;
  localparam int WALK_T  = 8;
  localparam int FLASH_T = 6;
  localparam int CLEAR_T = 2;
  localparam int MIN_GAP = 10;

  logic clk = 1'b0;
  logic resetN;
  walk_scheduler_if bus();

  walk_scheduler #(
    .WALK_T (WALK_T),
    .FLASH_T(FLASH_T),
    .CLEAR_T(CLEAR_T),
    .MIN_GAP(MIN_GAP),
    .CNT_W  (8)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs, written only by the model process.
  logic       exp_stop, exp_flash, exp_busy;
  logic [2:0] exp_walk, exp_rf;
  logic [1:0] exp_srv;
  int         m_rr;

  // Flag register model and stimulus controls, written only by the main initial block.
  logic [2:0] flags, hold, set_req, clr_mask;
  bit         clr_pend;
  bit         tick_rand;
  int         stop_mode;

  int         mon_walk_cnt, mon_pw_cnt, mon_gap_cnt, rf_n;
  logic [2:0] mon_walk_val;
  logic [15:0] mon_pw_bits;
  bit         seen_walk;
  logic [2:0] rf_log [8];
  logic [1:0] srv_log [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic set_exp(input bit stop, input logic [2:0] wl, input bit fl,
                         input logic [2:0] rf, input bit bsy);
    exp_stop = stop; exp_walk = wl; exp_flash = fl; exp_rf = rf; exp_busy = bsy;
  endtask

  task automatic nxt(output bit ok);
    @(posedge clk or negedge resetN);
    ok = (resetN === 1'b1);
  endtask

  function automatic int pick(input logic [2:0] f, input int rr);
    for (int i = 0; i < 3; i++) if (f[(rr + i) % 3]) return (rr + i) % 3;
    return 0;
  endfunction

  task automatic run_model();
    bit ok;
    int g;
    int n;
    logic [2:0] oh;
    forever begin
      set_exp(1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
      do begin nxt(ok); if (!ok) return; end while (bus.walkFlag == 3'b000);
      g = pick(bus.walkFlag, m_rr);
      exp_srv = 2'(g);
      oh = 3'(1 << g);
      set_exp(1'b1, 3'b000, 1'b0, 3'b000, 1'b1);
      do begin nxt(ok); if (!ok) return; end while (!bus.trafficStopped);
      set_exp(1'b1, oh, 1'b0, 3'b000, 1'b1);
      n = 0;
      while (n < WALK_T) begin nxt(ok); if (!ok) return; if (bus.tick) n++; end
      n = 0;
      while (n < FLASH_T) begin
        set_exp(1'b1, 3'b000, (n % 2) == 0, 3'b000, 1'b1);
        nxt(ok); if (!ok) return; if (bus.tick) n++;
      end
      set_exp(1'b1, 3'b000, 1'b0, 3'b000, 1'b1);
      n = 0;
      while (n < CLEAR_T) begin nxt(ok); if (!ok) return; if (bus.tick) n++; end
      m_rr = (g + 1) % 3;
      set_exp(1'b0, 3'b000, 1'b0, oh, 1'b1);
      n = 0;
      while (n < MIN_GAP) begin
        nxt(ok); if (!ok) return; if (bus.tick) n++;
        exp_rf = 3'b000;
      end
    end
  endtask

  always begin : model
    m_rr = 0;
    exp_srv = 2'd0;
    set_exp(1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    wait (resetN === 1'b1);
    run_model();
  end

  // ---------------- stimulus helpers ----------------
  task automatic mon_clear();
    mon_walk_cnt = 0; mon_walk_val = 3'b000; mon_pw_bits = '0; mon_pw_cnt = 0;
    mon_gap_cnt = 0; rf_n = 0; seen_walk = 1'b0;
  endtask

  task automatic step();
    logic [10:0] act, exp;
    @(negedge clk);
    act = {bus.trafficStopReq, bus.walkLight, bus.flashOn, bus.resetFlag, bus.servedIdx, bus.busy};
    exp = {exp_stop, exp_walk, exp_flash, exp_rf, exp_srv, exp_busy};
    chk("cycle_vs_model", 32'(act), 32'(exp));
    chk("lamps_exclusive", 32'(((bus.walkLight != 0) && (bus.flashOn || bus.resetFlag != 0)) ||
                               (bus.flashOn && bus.resetFlag != 0)), 32'd0);
    if (bus.walkLight != 3'b000) begin
      mon_walk_cnt++; mon_walk_val |= bus.walkLight; seen_walk = 1'b1;
    end else if (seen_walk && bus.trafficStopReq) begin
      mon_pw_bits = {mon_pw_bits[14:0], bus.flashOn}; mon_pw_cnt++;
    end
    if (bus.resetFlag != 3'b000) begin
      if (rf_n < 8) begin rf_log[rf_n] = bus.resetFlag; srv_log[rf_n] = bus.servedIdx; end
      rf_n++;
      seen_walk = 1'b0;
    end
    if (bus.busy && !bus.trafficStopReq) mon_gap_cnt++;
    // External flag register: clears one cycle after the pulse, new sets win.
    if (clr_pend) flags = flags & ~clr_mask;
    clr_pend = (bus.resetFlag != 3'b000);
    clr_mask = bus.resetFlag;
    flags = flags | set_req | hold;
    set_req = 3'b000;
    bus.walkFlag = flags;
    bus.tick = tick_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    case (stop_mode)
      0:       bus.trafficStopped = 1'b1;
      1:       bus.trafficStopped = 1'b0;
      default: bus.trafficStopped = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic wait_rf(input int n, input int max);
    int k = 0;
    while (rf_n < n && k < max) begin step(); k++; end
    chk("wait_resetflag_timeout", 32'(rf_n >= n), 32'd1);
  endtask

  task automatic wait_quiet(input int max);
    int k = 0;
    while ((flags != 3'b000 || bus.busy) && k < max) begin step(); k++; end
    chk("wait_idle_timeout", 32'(flags == 3'b000 && !bus.busy), 32'd1);
  endtask

  task automatic reset_pulse();
    resetN = 1'b0; step(); step(); resetN = 1'b1;
  endtask

  initial begin
    int k;
    resetN = 1'b0;
    bus.tick = 1'b0; bus.walkFlag = 3'b000; bus.trafficStopped = 1'b0;
    flags = 3'b000; hold = 3'b000; set_req = 3'b000; clr_mask = 3'b000; clr_pend = 1'b0;
    tick_rand = 1'b0; stop_mode = 0;
    mon_clear();
    repeat (3) step();
    chk("reset_outputs", 32'({bus.trafficStopReq, bus.walkLight, bus.flashOn, bus.resetFlag,
                              bus.servedIdx, bus.busy}), 32'd0);
    resetN = 1'b1;

    // Single request on NN with traffic already stopped, tick every cycle.
    mon_clear();
    set_req = 3'b010;
    wait_rf(1, 200);
    wait_quiet(100);
    chk("t1_walk_cycles", 32'(mon_walk_cnt), 32'd8);
    chk("t1_walk_value", 32'(mon_walk_val), 32'h2);
    chk("t1_flash_clear_cycles", 32'(mon_pw_cnt), 32'd8);
    chk("t1_flash_pattern", 32'(mon_pw_bits[7:0]), 32'hA8);
    chk("t1_resetflag", 32'(rf_log[0]), 32'h2);
    chk("t1_served_idx", 32'(srv_log[0]), 32'd1);
    chk("t1_resetflag_count", 32'(rf_n), 32'd1);
    chk("t1_gap_cycles", 32'(mon_gap_cnt), 32'd10);

    // All three held: round-robin from a fresh pointer.
    reset_pulse();
    mon_clear();
    hold = 3'b111;
    wait_rf(4, 400);
    hold = 3'b000;
    wait_quiet(300);
    for (int i = 0; i < 4; i++) begin
      chk("t2_rr_resetflag", 32'(rf_log[i]), 32'(1 << (i % 3)));
      chk("t2_rr_served", 32'(srv_log[i]), 32'(i % 3));
    end

    // Stalled in REQ until traffic stops, then gap/no re-grant of the served flag.
    mon_clear();
    stop_mode = 1;
    set_req = 3'b001;
    step(); step(); step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_req_stop", 32'(bus.trafficStopReq), 32'd1);
      chk("t3_req_no_walk", 32'(bus.walkLight), 32'd0);
    end
    stop_mode = 0;
    bus.trafficStopped = 1'b1;
    step();
    chk("t3_walk_next_cycle", 32'(bus.walkLight), 32'h1);
    wait_rf(1, 200);
    wait_quiet(100);
    chk("t4_gap_cycles", 32'(mon_gap_cnt), 32'd10);
    repeat (5) step();
    chk("t4_idle_busy", 32'(bus.busy), 32'd0);
    chk("t4_no_regrant", 32'(rf_n), 32'd1);

    // Async reset in FLASH; the still-set flag is served again from REQ.
    mon_clear();
    set_req = 3'b100;
    k = 0;
    while (mon_pw_cnt < 2 && k < 100) begin step(); k++; end
    chk("t5_reach_flash_timeout", 32'(mon_pw_cnt >= 2), 32'd1);
    #2 resetN = 1'b0;
    #1 chk("t5_async_reset_outputs", 32'({bus.trafficStopReq, bus.walkLight, bus.flashOn,
                                          bus.resetFlag, bus.servedIdx, bus.busy}), 32'd0);
    step(); step();
    resetN = 1'b1;
    mon_clear();
    step();
    chk("t5_restart_busy_req", 32'({bus.busy, bus.trafficStopReq}), 32'h3);
    chk("t5_restart_idx", 32'(bus.servedIdx), 32'd2);
    wait_rf(1, 200);
    chk("t5_restart_resetflag", 32'(rf_log[0]), 32'h4);
    wait_quiet(100);

    // Flag raised mid-phase waits for the next phase.
    mon_clear();
    set_req = 3'b001;
    k = 0;
    while (bus.walkLight == 3'b000 && k < 50) begin step(); k++; end
    chk("t6_walk_timeout", 32'(bus.walkLight), 32'h1);
    set_req = 3'b100;
    wait_rf(2, 300);
    chk("t6_first", 32'(rf_log[0]), 32'h1);
    chk("t6_second", 32'(rf_log[1]), 32'h4);
    wait_quiet(100);

    // Random soak with sparse ticks, jittery trafficStopped and one mid-run reset.
    tick_rand = 1'b1;
    stop_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) set_req = 3'($urandom_range(0, 7));
      if (i == 1500) reset_pulse();
      else step();
    end
    tick_rand = 1'b0;
    stop_mode = 0;
    wait_quiet(3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
